// File: rtl/mcpu_ctrl_fsm.sv
// Multicycle MIPS control FSM: fetch/decode/execute/mem/write-back sequencing.
// Optional jal/jr support is compiled in when MCPU_JAL_EN is defined.
module mcpu_ctrl_fsm #(
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OP,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               EXTOP,
  output logic               BranchNE,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrc_A,
  output logic [1:0]         ALUSrc_B,
  output logic [1:0]         MemWrBits,
  output logic [2:0]         MemRBits,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               err,
  output logic [3:0]         state_o
);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(15);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SH   = 6'b101001;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam int         CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit         TMO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TMO_V = CW'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_wait_st;
  logic          w_tmo;

  logic w_is_load;
  logic w_is_store;
  logic w_is_rtype;
  logic w_is_imm;
  logic w_is_br;
  logic w_is_j;
  logic w_is_jal;
  logic w_is_jr;
  logic w_is_jump;
  logic w_is_rexec;

  assign w_is_load  = (OP == OP_LW) || (OP == OP_LH) ||
                      (OP == OP_LHU) || (OP == OP_LB) ||
                      (OP == OP_LBU);
  assign w_is_store = (OP == OP_SW) || (OP == OP_SH) ||
                      (OP == OP_SB);
  assign w_is_rtype = (OP == OP_R);
  assign w_is_imm   = (OP == OP_ADDI) || (OP == OP_ANDI) ||
                      (OP == OP_ORI) || (OP == OP_SLTI) ||
                      (OP == OP_LUI);
  assign w_is_br    = (OP == OP_BEQ) || (OP == OP_BNE);
  assign w_is_j     = (OP == OP_J);

`ifdef MCPU_JAL_EN
  assign w_is_jal = (OP == OP_JAL);
  assign w_is_jr  = w_is_rtype && (Funct == FN_JR);
`else
  logic w_unused_funct;
  assign w_is_jal       = 1'b0;
  assign w_is_jr        = 1'b0;
  assign w_unused_funct = ^{Funct, OP_JAL, FN_JR};
`endif

  assign w_is_jump  = w_is_j || w_is_jal || w_is_jr;
  assign w_is_rexec = w_is_rtype && !w_is_jr;

  // Wait counter saturates so a stuck memory can never wrap back to zero.
  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                     (r_state == S_MEM_WR);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
  assign w_tmo     = TMO_EN && (w_cnt_inc >= TMO_V);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_state_n != r_state)
        r_cnt <= '0;
      else if (w_wait_st && !mem_ready)
        r_cnt <= w_cnt_inc;
    end
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE: w_state_n = S_FETCH;
      S_FETCH: begin
        if (mem_ready)  w_state_n = S_DECODE;
        else if (w_tmo) w_state_n = S_TRAP;
      end
      S_DECODE: begin
        unique case (1'b1)
          w_is_load,
          w_is_store: w_state_n = S_MEM_ADDR;
          w_is_rexec: w_state_n = S_EXEC_R;
          w_is_imm:   w_state_n = S_EXEC_I;
          w_is_br:    w_state_n = S_BRANCH;
          w_is_jump:  w_state_n = S_JUMP;
          default:    w_state_n = S_TRAP;
        endcase
      end
      S_MEM_ADDR:
        w_state_n = w_is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)  w_state_n = S_MEM_WB;
        else if (w_tmo) w_state_n = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready)  w_state_n = S_FETCH;
        else if (w_tmo) w_state_n = S_TRAP;
      end
      S_EXEC_R,
      S_EXEC_I: w_state_n = S_ALU_WB;
      S_MEM_WB,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP,
      S_TRAP:   w_state_n = S_FETCH;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    EXTOP       = 1'b0;
    BranchNE    = 1'b0;
    PCSrc       = 2'b00;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrc_A    = 2'b00;
    ALUSrc_B    = 2'b00;
    MemWrBits   = 2'b00;
    MemRBits    = 3'b000;
    ALUOp       = '0;
    err         = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrc_A = 2'b01;
        ALUSrc_B = 2'b01;
        ALUOp    = ALU_ADD;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      S_DECODE: begin
        ALUSrc_A = 2'b01;
        ALUSrc_B = 2'b11;
        ALUOp    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ALUSrc_B = 2'b10;
        EXTOP    = 1'b1;
        ALUOp    = ALU_ADD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        case (OP)
          OP_LH:   MemRBits = 3'b001;
          OP_LHU:  MemRBits = 3'b010;
          OP_LB:   MemRBits = 3'b011;
          OP_LBU:  MemRBits = 3'b100;
          default: MemRBits = 3'b000;
        endcase
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        case (OP)
          OP_SH:   MemWrBits = 2'b01;
          OP_SB:   MemWrBits = 2'b10;
          default: MemWrBits = 2'b00;
        endcase
      end
      S_EXEC_R: ALUOp = ALU_FUNCT;
      S_EXEC_I: begin
        ALUSrc_B = 2'b10;
        EXTOP    = (OP == OP_ADDI) || (OP == OP_SLTI);
        case (OP)
          OP_ANDI: ALUOp = ALU_AND;
          OP_ORI:  ALUOp = ALU_OR;
          OP_SLTI: ALUOp = ALU_SLT;
          OP_LUI:  ALUOp = ALU_LUI;
          default: ALUOp = ALU_ADD;
        endcase
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = w_is_rtype ? 2'b01 : 2'b00;
      end
      S_BRANCH: begin
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        BranchNE    = (OP == OP_BNE);
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = w_is_jr ? 2'b11 : 2'b10;
        if (w_is_jal) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      S_TRAP: err = 1'b1;
      default: ;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Table-driven bench for mcpu_ctrl_fsm (TIMEOUT=4) plus a
// hand-written asynchronous reset sequence.
module tb_mcpu_ctrl_fsm;

  localparam int TMO = 4;

  localparam logic [3:0] A_ADD = 4'd1;
  localparam logic [3:0] A_SUB = 4'd2;
  localparam logic [3:0] A_OR  = 4'd4;
  localparam logic [3:0] A_SLT = 4'd5;
  localparam logic [3:0] A_LUI = 4'd6;
  localparam logic [3:0] A_FN  = 4'd15;

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] FTCH = 4'd1;
  localparam logic [3:0] DEC  = 4'd2;
  localparam logic [3:0] MADR = 4'd3;
  localparam logic [3:0] MRD  = 4'd4;
  localparam logic [3:0] MWB  = 4'd5;
  localparam logic [3:0] MWR  = 4'd6;
  localparam logic [3:0] EXR  = 4'd7;
  localparam logic [3:0] EXI  = 4'd8;
  localparam logic [3:0] AWB  = 4'd9;
  localparam logic [3:0] BRN  = 4'd10;
  localparam logic [3:0] JMP  = 4'd11;
  localparam logic [3:0] TRP  = 4'd12;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IRWrite, MemRead;
  logic       MemWrite, RegWrite, EXTOP, BranchNE;
  logic [1:0] PCSrc, RegDst, MemtoReg;
  logic [1:0] ALUSrc_A, ALUSrc_B, MemWrBits;
  logic [2:0] MemRBits;
  logic [3:0] ALUOp;
  logic       err;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mcpu_ctrl_fsm #(
    .ALUOP_W(4),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .OP         (OP),
    .Funct      (Funct),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .EXTOP      (EXTOP),
    .BranchNE   (BranchNE),
    .PCSrc      (PCSrc),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrc_A   (ALUSrc_A),
    .ALUSrc_B   (ALUSrc_B),
    .MemWrBits  (MemWrBits),
    .MemRBits   (MemRBits),
    .ALUOp      (ALUOp),
    .err        (err),
    .state_o    (state_o)
  );

  typedef struct packed {
    logic       pcw, pcwc, irw, mrd, mwr, rgw, ext, bne;
    logic [1:0] pcsrc, rdst, m2r, asa, asb, wbits;
    logic [2:0] rbits;
    logic [3:0] aop;
    logic       err;
  } ctl_t;

  ctl_t act;
  assign act = {PCWrite, PCWriteCond, IRWrite, MemRead,
                MemWrite, RegWrite, EXTOP, BranchNE,
                PCSrc, RegDst, MemtoReg, ALUSrc_A,
                ALUSrc_B, MemWrBits, MemRBits, ALUOp, err};

  typedef struct {
    string      tag;
    logic [5:0] op;
    logic [5:0] fn;
    logic       mr;
    logic [3:0] st;
    ctl_t       exp;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
  endtask

  function automatic void add(string tag, logic [5:0] op,
                              logic [5:0] fn, logic mr,
                              logic [3:0] st, ctl_t e);
    vec_t v;
    v.tag = tag; v.op = op; v.fn = fn;
    v.mr = mr; v.st = st; v.exp = e;
    vq.push_back(v);
  endfunction

  function automatic ctl_t c_fetch(logic mr);
    ctl_t c = '0;
    c.mrd = 1'b1; c.asa = 2'b01; c.asb = 2'b01;
    c.aop = A_ADD; c.irw = mr; c.pcw = mr;
    return c;
  endfunction

  function automatic ctl_t c_dec();
    ctl_t c = '0;
    c.asa = 2'b01; c.asb = 2'b11; c.aop = A_ADD;
    return c;
  endfunction

  function automatic ctl_t c_madr();
    ctl_t c = '0;
    c.asb = 2'b10; c.ext = 1'b1; c.aop = A_ADD;
    return c;
  endfunction

  function automatic ctl_t c_mrd(logic [2:0] b);
    ctl_t c = '0;
    c.mrd = 1'b1; c.rbits = b;
    return c;
  endfunction

  function automatic ctl_t c_mwb();
    ctl_t c = '0;
    c.rgw = 1'b1; c.m2r = 2'b01;
    return c;
  endfunction

  function automatic ctl_t c_mwr(logic [1:0] b);
    ctl_t c = '0;
    c.mwr = 1'b1; c.wbits = b;
    return c;
  endfunction

  function automatic ctl_t c_exr();
    ctl_t c = '0;
    c.aop = A_FN;
    return c;
  endfunction

  function automatic ctl_t c_exi(logic ext, logic [3:0] aop);
    ctl_t c = '0;
    c.asb = 2'b10; c.ext = ext; c.aop = aop;
    return c;
  endfunction

  function automatic ctl_t c_awb(logic [1:0] rd);
    ctl_t c = '0;
    c.rgw = 1'b1; c.rdst = rd;
    return c;
  endfunction

  function automatic ctl_t c_br(logic ne);
    ctl_t c = '0;
    c.aop = A_SUB; c.pcwc = 1'b1;
    c.pcsrc = 2'b01; c.bne = ne;
    return c;
  endfunction

  function automatic ctl_t c_jmp(logic [1:0] src, logic link);
    ctl_t c = '0;
    c.pcw = 1'b1; c.pcsrc = src;
    if (link) begin
      c.rgw = 1'b1; c.rdst = 2'b10; c.m2r = 2'b10;
    end
    return c;
  endfunction

  function automatic ctl_t c_trap();
    ctl_t c = '0;
    c.err = 1'b1;
    return c;
  endfunction

  initial begin
    // R-type add from reset; mem_ready low in DECODE is ignored
    add("add.idle", 6'h00, 6'h20, 1'b1, IDLE, '0);
    add("add.fet",  6'h00, 6'h20, 1'b1, FTCH, c_fetch(1'b1));
    add("add.dec",  6'h00, 6'h20, 1'b0, DEC,  c_dec());
    add("add.ex",   6'h00, 6'h20, 1'b1, EXR,  c_exr());
    add("add.wb",   6'h00, 6'h20, 1'b1, AWB,  c_awb(2'b01));
    // lw with three wait cycles in MEM_RD
    add("lw.fet",   6'h23, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("lw.dec",   6'h23, 6'h00, 1'b1, DEC,  c_dec());
    add("lw.adr",   6'h23, 6'h00, 1'b0, MADR, c_madr());
    for (int i = 0; i < 3; i++)
      add("lw.rdw", 6'h23, 6'h00, 1'b0, MRD,  c_mrd(3'b000));
    add("lw.rd",    6'h23, 6'h00, 1'b1, MRD,  c_mrd(3'b000));
    add("lw.wb",    6'h23, 6'h00, 1'b0, MWB,  c_mwb());
    // lhu and lb extension selects
    add("lhu.fet",  6'h25, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("lhu.dec",  6'h25, 6'h00, 1'b1, DEC,  c_dec());
    add("lhu.adr",  6'h25, 6'h00, 1'b1, MADR, c_madr());
    add("lhu.rd",   6'h25, 6'h00, 1'b1, MRD,  c_mrd(3'b010));
    add("lhu.wb",   6'h25, 6'h00, 1'b1, MWB,  c_mwb());
    add("lb.fet",   6'h20, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("lb.dec",   6'h20, 6'h00, 1'b1, DEC,  c_dec());
    add("lb.adr",   6'h20, 6'h00, 1'b1, MADR, c_madr());
    add("lb.rd",    6'h20, 6'h00, 1'b1, MRD,  c_mrd(3'b011));
    add("lb.wb",    6'h20, 6'h00, 1'b1, MWB,  c_mwb());
    // sb with one wait cycle, sh without
    add("sb.fet",   6'h28, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("sb.dec",   6'h28, 6'h00, 1'b1, DEC,  c_dec());
    add("sb.adr",   6'h28, 6'h00, 1'b1, MADR, c_madr());
    add("sb.wrw",   6'h28, 6'h00, 1'b0, MWR,  c_mwr(2'b10));
    add("sb.wr",    6'h28, 6'h00, 1'b1, MWR,  c_mwr(2'b10));
    add("sh.fet",   6'h29, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("sh.dec",   6'h29, 6'h00, 1'b1, DEC,  c_dec());
    add("sh.adr",   6'h29, 6'h00, 1'b1, MADR, c_madr());
    add("sh.wr",    6'h29, 6'h00, 1'b1, MWR,  c_mwr(2'b01));
    // branches
    add("bne.fet",  6'h05, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("bne.dec",  6'h05, 6'h00, 1'b1, DEC,  c_dec());
    add("bne.br",   6'h05, 6'h00, 1'b0, BRN,  c_br(1'b1));
    add("beq.fet",  6'h04, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("beq.dec",  6'h04, 6'h00, 1'b1, DEC,  c_dec());
    add("beq.br",   6'h04, 6'h00, 1'b1, BRN,  c_br(1'b0));
    // immediates
    add("ori.fet",  6'h0d, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("ori.dec",  6'h0d, 6'h00, 1'b0, DEC,  c_dec());
    add("ori.ex",   6'h0d, 6'h00, 1'b0, EXI,  c_exi(1'b0, A_OR));
    add("ori.wb",   6'h0d, 6'h00, 1'b1, AWB,  c_awb(2'b00));
    add("slti.fet", 6'h0a, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("slti.dec", 6'h0a, 6'h00, 1'b1, DEC,  c_dec());
    add("slti.ex",  6'h0a, 6'h00, 1'b1, EXI,  c_exi(1'b1, A_SLT));
    add("slti.wb",  6'h0a, 6'h00, 1'b1, AWB,  c_awb(2'b00));
    add("lui.fet",  6'h0f, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("lui.dec",  6'h0f, 6'h00, 1'b1, DEC,  c_dec());
    add("lui.ex",   6'h0f, 6'h00, 1'b1, EXI,  c_exi(1'b0, A_LUI));
    add("lui.wb",   6'h0f, 6'h00, 1'b1, AWB,  c_awb(2'b00));
    // jump
    add("j.fet",    6'h02, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("j.dec",    6'h02, 6'h00, 1'b1, DEC,  c_dec());
    add("j.jmp",    6'h02, 6'h00, 1'b1, JMP,  c_jmp(2'b10, 1'b0));
    // illegal opcode
    add("ill.fet",  6'h3f, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("ill.dec",  6'h3f, 6'h00, 1'b1, DEC,  c_dec());
    add("ill.trap", 6'h3f, 6'h00, 1'b1, TRP,  c_trap());
    // fetch timeout: four wait cycles then trap
    for (int i = 0; i < TMO; i++)
      add("tmo.fet", 6'h00, 6'h20, 1'b0, FTCH, c_fetch(1'b0));
    add("tmo.trap", 6'h00, 6'h20, 1'b0, TRP,  c_trap());
    // ready on the timeout cycle wins
    for (int i = 0; i < TMO - 1; i++)
      add("win.fetw", 6'h02, 6'h00, 1'b0, FTCH, c_fetch(1'b0));
    add("win.fet",  6'h02, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("win.dec",  6'h02, 6'h00, 1'b0, DEC,  c_dec());
    add("win.jmp",  6'h02, 6'h00, 1'b0, JMP,  c_jmp(2'b10, 1'b0));
    // store timeout
    add("swt.fet",  6'h2b, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("swt.dec",  6'h2b, 6'h00, 1'b1, DEC,  c_dec());
    add("swt.adr",  6'h2b, 6'h00, 1'b1, MADR, c_madr());
    for (int i = 0; i < TMO; i++)
      add("swt.wrw", 6'h2b, 6'h00, 1'b0, MWR, c_mwr(2'b00));
    add("swt.trap", 6'h2b, 6'h00, 1'b0, TRP,  c_trap());
    // jal and jr
    add("jal.fet",  6'h03, 6'h00, 1'b1, FTCH, c_fetch(1'b1));
    add("jal.dec",  6'h03, 6'h00, 1'b1, DEC,  c_dec());
`ifdef MCPU_JAL_EN
    add("jal.jmp",  6'h03, 6'h00, 1'b1, JMP,  c_jmp(2'b10, 1'b1));
    add("jr.fet",   6'h00, 6'h08, 1'b1, FTCH, c_fetch(1'b1));
    add("jr.dec",   6'h00, 6'h08, 1'b1, DEC,  c_dec());
    add("jr.jmp",   6'h00, 6'h08, 1'b1, JMP,  c_jmp(2'b11, 1'b0));
`else
    add("jal.trap", 6'h03, 6'h00, 1'b1, TRP,  c_trap());
    add("jr.fet",   6'h00, 6'h08, 1'b1, FTCH, c_fetch(1'b1));
    add("jr.dec",   6'h00, 6'h08, 1'b1, DEC,  c_dec());
    add("jr.ex",    6'h00, 6'h08, 1'b1, EXR,  c_exr());
    add("jr.wb",    6'h00, 6'h08, 1'b1, AWB,  c_awb(2'b01));
`endif

    rst = 1'b0;
    OP = 6'h00;
    Funct = 6'h00;
    mem_ready = 1'b1;
    #2;
    chk("rst.st",  32'(state_o), 32'(IDLE));
    chk("rst.out", 32'(act), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      OP        = vq[i].op;
      Funct     = vq[i].fn;
      mem_ready = vq[i].mr;
      #1;
      chk({vq[i].tag, ".st"},  32'(state_o), 32'(vq[i].st));
      chk({vq[i].tag, ".out"}, 32'(act), 32'(vq[i].exp));
      @(negedge clk);
    end

    // asynchronous reset in the middle of a held store
    OP = 6'h2b;
    Funct = 6'h00;
    mem_ready = 1'b1;
    #1;
    chk("ar.fet", 32'(state_o), 32'(FTCH));
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("ar.mwr.st", 32'(state_o), 32'(MWR));
    chk("ar.mwr.we", 32'(MemWrite), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar.async.we",  32'(MemWrite), 32'd0);
    chk("ar.async.st",  32'(state_o), 32'(IDLE));
    chk("ar.async.out", 32'(act), 32'h0);
    @(negedge clk);
    chk("ar.hold.st", 32'(state_o), 32'(IDLE));
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("ar.rel.st", 32'(state_o), 32'(IDLE));
    @(negedge clk);
    #1;
    chk("ar.fet.st",  32'(state_o), 32'(FTCH));
    chk("ar.fet.out", 32'(act), 32'(c_fetch(1'b1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mcpu_ctrl_fsm.md
# mcpu_ctrl_fsm

Parametrised multicycle MIPS control unit for the MCPU datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back for R-type, immediate, load/store (word, half, byte), branch and jump instructions. It adds a memory ready handshake with wait states, a bounded wait timeout, and illegal-opcode trapping. It sits between the instruction register (OP, Funct) and the datapath muxes, register file, ALU and memory.

## Interface
- ALUOP_W, 4: ALUOp width; codes are `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`, `ALU_LUI` from ctrl_encode_def.v, plus `ALU_FUNCT` (R-type, ALU decodes Funct).
- TIMEOUT, 255: maximum wait cycles on mem_ready before trap; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- OP  in  6  opcode from instruction register.
- Funct  in  6  function field.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, EXTOP, BranchNE  out  1 each  datapath strobes and selects (EXTOP=1 sign-extend; BranchNE=1 branch on not-equal).
- PCSrc, RegDst, MemtoReg, ALUSrc_A, ALUSrc_B, MemWrBits  out  2 each  mux selects; MemWrBits 00 word, 01 half, 10 byte.
- MemRBits  out  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
- ALUOp  out  ALUOP_W  ALU operation.
- err  out  1  one-cycle pulse on illegal opcode or timeout.
- state_o  out  4  current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, TRAP.
- IDLE -> FETCH unconditionally.
- FETCH: MemRead=1, ALUSrc_A=01 (PC), ALUSrc_B=01 (4), ALUOp=`ALU_ADD`, PCSrc=00. IRWrite and PCWrite asserted only when mem_ready=1; then -> DECODE, else stay.
- DECODE: ALUSrc_A=01, ALUSrc_B=11 (sext<<2), ALUOp=`ALU_ADD` (branch target precompute). Next: lw/lh/lhu/lb/lbu/sw/sh/sb -> MEM_ADDR; R-type -> EXEC_R; addi/andi/ori/slti/lui -> EXEC_I; beq/bne -> BRANCH; j -> JUMP; other -> TRAP.
- MEM_ADDR: ALUSrc_A=00 (rs), ALUSrc_B=10 (imm), EXTOP=1, ALUOp=`ALU_ADD`; loads -> MEM_RD, stores -> MEM_WR.
- MEM_RD: MemRead=1, MemRBits from OP; -> MEM_WB on mem_ready. MEM_WB: RegWrite=1, RegDst=00 (rt), MemtoReg=01; -> FETCH.
- MEM_WR: MemWrite=1 held until mem_ready, MemWrBits from OP; -> FETCH on mem_ready.
- EXEC_R: ALUSrc_A=00, ALUSrc_B=00, ALUOp=`ALU_FUNCT`; -> ALU_WB (RegDst=01 rd). EXEC_I: ALUSrc_B=10, EXTOP=1 for addi/slti else 0, ALUOp per opcode; -> ALU_WB (RegDst=00). ALU_WB: RegWrite=1, MemtoReg=00; -> FETCH.
- BRANCH: ALUOp=`ALU_SUB`, PCWriteCond=1, PCSrc=01, BranchNE=1 for bne; -> FETCH.
- JUMP: PCWrite=1, PCSrc=10; -> FETCH.
- TRAP: err=1 for one cycle, all strobes 0, no PC update; -> FETCH (instruction skipped, PC already +4).
- Wait counter: cleared on entering FETCH/MEM_RD/MEM_WR, increments each cycle mem_ready=0; reaching TIMEOUT -> TRAP. Saturates, never wraps.
- Unlisted outputs are 0 in each state.

## Timing
- Reset (rst=0, any time, mid-access included): state=IDLE, wait counter 0, every output 0 immediately; first FETCH one cycle after rst released.
- Outputs are decoded from the state register; only IRWrite/PCWrite in FETCH are gated by mem_ready combinationally.
- With mem_ready tied 1: R/I-type 4 cycles, load 5, store 4, branch/jump 3.
- mem_ready asserted in a non-memory state is ignored.
- mem_ready and timeout reached in same cycle: mem_ready wins.

## Configuration
- MCPU_JAL_EN defined: jal (000011) -> JUMP with RegWrite=1, RegDst=10 ($31), MemtoReg=10 (PC); R-type Funct 001000 (jr) -> JUMP with PCSrc=11 (rs), no RegWrite. Undefined: jal traps; jr executes as ordinary R-type through EXEC_R.

## Test plan
- Reset released, mem_ready=1, OP=000000 Funct=100000 -> states IDLE,FETCH,DECODE,EXEC_R,ALU_WB,FETCH; RegWrite=1, RegDst=01 only in ALU_WB.
- lw (100011), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, MemRead=1 throughout, RegWrite=1 exactly once in MEM_WB.
- sb (101000) -> MemWrBits=10, MemWrite=1 in MEM_WR only; bne (000101) -> PCWriteCond=1, BranchNE=1, PCSrc=01 in BRANCH.
- TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 wait cycles, err pulse 1 cycle, IRWrite never 1.
- OP=111111 -> DECODE, TRAP, err=1, back to FETCH; with MCPU_JAL_EN, OP=000011 -> RegWrite=1, RegDst=10, PCSrc=10.
- rst=0 during MEM_WR with MemWrite=1 -> MemWrite=0 asynchronously, state_o=IDLE.
